muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; all data paths are fixed at 32 bits (word_t).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request valid; sampled only in IDLE.
REQ-005 op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  multiplicand / dividend (rs).
REQ-007 b  input  32  multiplier / divisor (rt).
REQ-008 flush  input  1  abort in-flight operation (pipeline flush/exception).
REQ-009 busy  output  1  high whenever state != IDLE; used as execute-stage stall.
REQ-010 done  output  1  one-cycle pulse; hi/lo valid and to be written to HILO.
REQ-011 hi  output  32  result high word (product[63:32] or remainder).
REQ-012 lo  output  32  result low word (product[31:0] or quotient).

Function
REQ-013 The block SHALL implement states IDLE, CALC, DONE.
REQ-014 IDLE: start=1 and flush=0 SHALL latch op, operand magnitudes and result signs, clear a 6-bit iteration counter, and go to CALC.
REQ-015 CALC: exactly 32 cycles, one bit per cycle (shift-add multiply, restoring divide on unsigned magnitudes); counter increments each cycle; counter==31 -> DONE.
REQ-016 DONE: done=1 for exactly one cycle with final hi/lo; next state IDLE.
REQ-017 Latency: start accepted at cycle N -> done at cycle N+33; busy high cycles N+1..N+33 inclusive.
REQ-018 Back-to-back: a new start is accepted in the cycle after DONE (busy low); start while busy SHALL be ignored.
REQ-019 Signed ops: operands converted to magnitude at accept; product negated iff signs differ; quotient negated iff signs differ; remainder takes sign of dividend.
REQ-020 Unsigned ops: no sign handling; MULTU gives full 64-bit unsigned product.
REQ-021 Divide by zero (DIV or DIVU, b==0): hi = a (original), lo = 32'hFFFF_FFFF, same 33-cycle latency.
REQ-022 Signed overflow DIV 0x8000_0000 / 0xFFFF_FFFF: lo = 0x8000_0000, hi = 0.
REQ-023 flush=1 in any state SHALL force IDLE next cycle with no done pulse; flush has priority over start and over DONE (done forced 0 in that cycle).
REQ-024 hi/lo SHALL update only on the DONE cycle and hold their value otherwise (including after flush).
REQ-025 done and busy SHALL be registered outputs, glitch-free.

Reset
REQ-026 reset=1 SHALL, at the next rising edge, force IDLE, counter=0, busy=0, done=0, hi=0, lo=0, and discard any in-flight operation.
REQ-027 reset SHALL take priority over flush and start in the same cycle.

Verification
REQ-028 MULT a=0xFFFF_FFFD (-3), b=5 -> done at N+33, hi=0xFFFF_FFFF, lo=0xFFFF_FFF1; busy high N+1..N+33.
REQ-029 MULTU a=b=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001; immediate second start at N+34 (DIVU 100/7) -> lo=14, hi=2 at N+67.
REQ-030 DIV a=-7, b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; DIV a=0x8000_0000, b=-1 -> lo=0x8000_0000, hi=0.
REQ-031 DIVU a=7, b=0 -> hi=7, lo=0xFFFF_FFFF after 33 cycles.
REQ-032 Start DIV 100/3, flush at N+10 -> busy=0 at N+11, no done ever, hi/lo unchanged; new start at N+11 completes normally at N+44.
REQ-033 reset asserted at N+20 mid-MULT -> N+21: busy=0, done=0, hi=lo=0; start held high during the same reset cycle is ignored.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a 33-cycle accept-to-done latency and HI/LO result registers.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef logic [31:0] word_t;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_reg, state_next;
  logic [5:0] count_reg, count_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  word_t      hi_reg, hi_next;
  word_t      lo_reg, lo_next;

  // Operation context captured at accept time
  logic       is_div_reg, is_div_next;
  logic       neg_main_reg, neg_main_next;
  logic       neg_rem_reg, neg_rem_next;
  logic       div_zero_reg, div_zero_next;
  word_t      a_orig_reg, a_orig_next;
  word_t      opnd_reg, opnd_next;
  word_t      acc_hi_reg, acc_hi_next;
  word_t      acc_lo_reg, acc_lo_next;

  // Operand magnitudes and signs at accept
  logic       is_signed;
  logic       a_neg, b_neg;
  word_t      a_mag, b_mag;

  always_comb begin
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = is_signed & a[31];
    b_neg     = is_signed & b[31];
    a_mag     = a_neg ? (~a + 32'd1) : a;
    b_mag     = b_neg ? (~b + 32'd1) : b;
  end

  // One iteration of the multiply or divide datapath
  logic [32:0] mul_sum;
  logic [32:0] rem_shift;
  logic        rem_ge;
  word_t       rem_sub;
  word_t       step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : 33'd0);
    rem_shift = {acc_hi_reg, acc_lo_reg[31]};
    rem_ge    = rem_shift >= {1'b0, opnd_reg};
    rem_sub   = rem_shift[31:0] - opnd_reg;
    if (is_div_reg) begin
      step_hi = rem_ge ? rem_sub : rem_shift[31:0];
      step_lo = {acc_lo_reg[30:0], rem_ge};
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], acc_lo_reg[31:1]};
    end
  end

  // Sign correction and special cases applied to the final iteration
  logic [63:0] prod_mag, prod_fix;
  word_t       final_hi, final_lo;

  always_comb begin
    prod_mag = {step_hi, step_lo};
    prod_fix = neg_main_reg ? (~prod_mag + 64'd1) : prod_mag;
    if (is_div_reg) begin
      if (div_zero_reg) begin
        final_hi = a_orig_reg;
        final_lo = 32'hFFFF_FFFF;
      end else begin
        final_hi = neg_rem_reg  ? (~step_hi + 32'd1) : step_hi;
        final_lo = neg_main_reg ? (~step_lo + 32'd1) : step_lo;
      end
    end else begin
      final_hi = prod_fix[63:32];
      final_lo = prod_fix[31:0];
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    hi_next       = hi_reg;
    lo_next       = lo_reg;
    is_div_next   = is_div_reg;
    neg_main_next = neg_main_reg;
    neg_rem_next  = neg_rem_reg;
    div_zero_next = div_zero_reg;
    a_orig_next   = a_orig_reg;
    opnd_next     = opnd_reg;
    acc_hi_next   = acc_hi_reg;
    acc_lo_next   = acc_lo_reg;

    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_next    = S_CALC;
            count_next    = 6'd0;
            is_div_next   = (op == OP_DIV) || (op == OP_DIVU);
            neg_main_next = a_neg ^ b_neg;
            neg_rem_next  = a_neg;
            div_zero_next = (b == 32'd0);
            a_orig_next   = a;
            acc_hi_next   = 32'd0;
            // Multiply keeps the multiplicand aside and shifts the multiplier
            // out of acc_lo; divide shifts the dividend out of acc_lo.
            if ((op == OP_MULT) || (op == OP_MULTU)) begin
              opnd_next   = a_mag;
              acc_lo_next = b_mag;
            end else begin
              opnd_next   = b_mag;
              acc_lo_next = a_mag;
            end
          end
        end
        S_CALC: begin
          acc_hi_next = step_hi;
          acc_lo_next = step_lo;
          count_next  = count_reg + 6'd1;
          if (count_reg == 6'd31) begin
            state_next = S_DONE;
            hi_next    = final_hi;
            lo_next    = final_lo;
          end
        end
        S_DONE: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end

    busy_next = (state_next != S_IDLE);
    done_next = (state_next == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      count_reg    <= 6'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      is_div_reg   <= 1'b0;
      neg_main_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      a_orig_reg   <= 32'd0;
      opnd_reg     <= 32'd0;
      acc_hi_reg   <= 32'd0;
      acc_lo_reg   <= 32'd0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      hi_reg       <= hi_next;
      lo_reg       <= lo_next;
      is_div_reg   <= is_div_next;
      neg_main_reg <= neg_main_next;
      neg_rem_reg  <= neg_rem_next;
      div_zero_reg <= div_zero_next;
      a_orig_reg   <= a_orig_next;
      opnd_reg     <= opnd_next;
      acc_hi_reg   <= acc_hi_next;
      acc_lo_reg   <= acc_lo_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit: latency, signed/unsigned results,
// divide-by-zero, overflow, back-to-back, flush and mid-operation reset.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in the current cycle N; returns in cycle N+1.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  // Called in cycle N+1; returns in the cycle done is seen (or at the bound).
  // lat is the cycle offset from N, busy_cnt counts busy cycles seen on the way.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = 1;
    busy_cnt = 0;
    while (1) begin
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1 || lat >= 100) break;
      next_cycle();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 00000000", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 00000000", lo); end
    $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
  endtask

  task automatic test_mult();
    int lat, bc;
    start_op(2'd0, 32'hFFFF_FFFD, 32'd5);
    wait_done(lat, bc);
    $display("MULT -3*5: lat=%0d busy_cycles=%0d hi=%h lo=%h", lat, bc, hi, lo);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency got %0d want 33", lat); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d want 33", bc); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo got %h want fffffff1", lo); end
    next_cycle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_after got %b want 0", busy); end
    checks++; if (lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo_hold got %h want fffffff1", lo); end

    start_op(2'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    wait_done(lat, bc);
    $display("MULT -2*-3: lat=%0d hi=%h lo=%h", lat, hi, lo);
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL mult_negneg_hi got %h want 00000000", hi); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL mult_negneg_lo got %h want 00000006", lo); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    start_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    $display("MULTU ffffffff^2: lat=%0d hi=%h lo=%h", lat, hi, lo);
    checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency got %0d want 33", lat); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got %h want 00000001", lo); end
    next_cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_gap got %b want 0", busy); end
    start_op(2'd3, 32'd100, 32'd7);
    wait_done(lat, bc);
    $display("DIVU 100/7 back-to-back: lat=%0d hi=%h lo=%h", lat, hi, lo);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL b2b_lo got %h want 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL b2b_hi got %h want 00000002", hi); end
    next_cycle();
  endtask

  task automatic test_start_while_busy();
    int lat, bc;
    start_op(2'd3, 32'd100, 32'd7);
    for (int i = 0; i < 4; i++) next_cycle();
    op    = 2'd0;
    a     = 32'd9;
    b     = 32'd9;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    wait_done(lat, bc);
    lat += 5;
    $display("DIVU 100/7 with ignored start: lat=%0d hi=%h lo=%h", lat, hi, lo);
    checks++; if (lat !== 33) begin errors++; $display("FAIL busy_start_latency got %0d want 33", lat); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL busy_start_lo got %h want 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL busy_start_hi got %h want 00000002", hi); end
    next_cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got %b want 0", busy); end
  endtask

  task automatic test_div();
    int lat, bc;
    start_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bc);
    $display("DIV -7/2: lat=%0d hi=%h lo=%h", lat, hi, lo);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got %h want ffffffff", hi); end
    next_cycle();

    start_op(2'd2, 32'd7, 32'hFFFF_FFFE);
    wait_done(lat, bc);
    $display("DIV 7/-2: lat=%0d hi=%h lo=%h", lat, hi, lo);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negdiv_lo got %h want fffffffd", lo); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL div_negdiv_hi got %h want 00000001", hi); end
    next_cycle();

    start_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bc);
    $display("DIV overflow: lat=%0d hi=%h lo=%h", lat, hi, lo);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_ovf_latency got %0d want 33", lat); end
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL div_ovf_hi got %h want 00000000", hi); end
    next_cycle();
  endtask

  task automatic test_div_zero();
    int lat, bc;
    start_op(2'd3, 32'd7, 32'd0);
    wait_done(lat, bc);
    $display("DIVU 7/0: lat=%0d hi=%h lo=%h", lat, hi, lo);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divz_latency got %0d want 33", lat); end
    checks++; if (hi !== 32'd7) begin errors++; $display("FAIL divz_hi got %h want 00000007", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo got %h want ffffffff", lo); end
    next_cycle();

    start_op(2'd2, 32'hFFFF_FFFB, 32'd0);
    wait_done(lat, bc);
    $display("DIV -5/0: lat=%0d hi=%h lo=%h", lat, hi, lo);
    checks++; if (hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL divz_signed_hi got %h want fffffffb", hi); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_signed_lo got %h want ffffffff", lo); end
    next_cycle();
  endtask

  task automatic test_flush();
    int lat, bc;
    logic [31:0] hi_before, lo_before;
    hi_before = hi;
    lo_before = lo;
    start_op(2'd2, 32'd100, 32'd3);
    for (int i = 0; i < 9; i++) next_cycle();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    $display("flush at N+10: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done got %b want 0", done); end
    checks++; if (hi !== hi_before) begin errors++; $display("FAIL flush_hi_hold got %h want %h", hi, hi_before); end
    checks++; if (lo !== lo_before) begin errors++; $display("FAIL flush_lo_hold got %h want %h", lo, lo_before); end
    start_op(2'd2, 32'd100, 32'd3);
    wait_done(lat, bc);
    $display("DIV 100/3 after flush: lat=%0d hi=%h lo=%h", lat, hi, lo);
    checks++; if (lat !== 33) begin errors++; $display("FAIL flush_restart_latency got %0d want 33", lat); end
    checks++; if (lo !== 32'd33) begin errors++; $display("FAIL flush_restart_lo got %h want 00000021", lo); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL flush_restart_hi got %h want 00000001", hi); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    start_op(2'd0, 32'd1234, 32'd5678);
    for (int i = 0; i < 19; i++) next_cycle();
    reset = 1'b1;
    start = 1'b1;
    flush = 1'b1;
    next_cycle();
    reset = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    $display("reset at N+20: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL midreset_hi got %h want 00000000", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL midreset_lo got %h want 00000000", lo); end
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b0 || done !== 1'b0) break;
      next_cycle();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_start_ignored busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_no_done got %b want 0", done); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op     = 2'd0;
    a      = 32'd0;
    b      = 32'd0;
    next_cycle();
    test_reset();
    test_mult();
    test_back_to_back();
    test_start_while_busy();
    test_div();
    test_div_zero();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
